aes128_dec_iter: RTL
====================

// Module: aes128_dec_iter
// PURPOSE
//  Iterative AES-128 decryptor (FIPS-197 inverse cipher), one round per clock.
//  Receiving end of the encryption path: it takes ciphertext blocks from the
//  encryption layer or the link, and returns plaintext under a valid/ready
//  handshake. It is the area-lean sequential counterpart of the unrolled
//  combinational decryption layers and is used in the board self-test
//  (encrypt -> decrypt -> compare).
// PARAMETERS
//  NR      10   number of rounds; fixed for AES-128, other values unsupported
// PORTS
//  clk        in   1    single clock; all state updates on rising edge
//  reset      in   1    synchronous, active-high reset
//  in_valid   in   1    ciphertext + key presented
//  in_ready   out  1    block accepts input (high only in IDLE)
//  in_data    in   128  ciphertext, byte 0 = [127:120]
//  in_key     in   128  cipher key (round key 0), byte 0 = [127:120]
//  out_valid  out  1    plaintext valid; held until accepted
//  out_ready  in   1    downstream accepts plaintext
//  out_data   out  128  plaintext, byte 0 = [127:120]
// BEHAVIOUR
//  - Reset, synchronous active-high: state=IDLE, in_ready=1, out_valid=0,
//    out_data=0, round counter=0, key cache invalidated. Reset mid-operation
//    aborts the block with no output.
//  - Accept: in_valid & in_ready on edge T. Register data and key; rcon=0x01.
//  - FSM: IDLE -> KEXP -> ARK -> DEC -> DONE -> IDLE.
//  - KEXP, 10 cycles: forward key schedule, 1 round key per cycle; rcon=xtime(rcon).
//    At exit the key reg = rk10 and rcon = 0x36.
//  - ARK, 1 cycle: state ^= rk10; key steps back to rk9.
//  - DEC, 10 cycles, r=9..0: state = InvSubBytes(InvShiftRows(state)) ^ rk_r,
//    then InvMixColumns if r!=0. Key steps back one round per cycle:
//    w[i-4]=w[i]^w[i-1]; for i%4==0, w[i-4]=w[i]^SubWord(RotWord(w[i-1]))^rcon.
//    rcon = inverse xtime (0x36 -> ... -> 0x01).
//  - DONE: out_valid=1 from edge T+21 and out_data=plaintext. out_data must stay
//    stable while out_valid & !out_ready. When out_valid & out_ready, go to
//    IDLE. in_ready=1 on the next cycle; no input is accepted in that same cycle.
//  - Throughput: 1 block per 22 cycles minimum with out_ready tied high.
//  - in_valid while busy: ignored. in_data and in_key are not sampled after the
//    accept cycle.
//  - All byte arithmetic is GF(2^8) mod 0x11B. There is no width growth; every
//    datapath register is exactly 128 bits.
// CONFIGURATION
//  AES_DEC_KEY_CACHE_EN defined: rk10 and its source key are kept after
//    every KEXP. On accept, if the cache is valid and in_key equals the cached
//    key, KEXP is skipped: ARK is entered directly and out_valid is set at T+11.
//    A differing key takes the full path and refreshes the cache. Reset
//    invalidates the cache.
//  Not defined: no cache registers. KEXP always runs; latency is always 21.
// STRUCTURE
//  aes_pkg: SBOX/INV_SBOX tables, RCON constants, xtime/gmul functions,
//    FSM state encoding, AES_NR/AES_BLK_W constants.
//  Sub-module aes_inv_round_comb: combinational InvShiftRows, InvSubBytes,
//    AddRoundKey and optional InvMixColumns, selected by a last-round input.
//  Top level: FSM, round counter, rcon reg, key-schedule step forward/backward,
//    key cache.
// TESTING
//  1 FIPS-197 C.1: key 000102..0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a
//    -> pt 00112233445566778899aabbccddeeff, out_valid at T+21.
//  2 FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32
//    -> pt 3243f6a8885a308d313198a2e0370734.
//  3 Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data stable,
//    in_ready=0; with out_ready=1, in_ready=1 on the next cycle.
//  4 reset=1 at DEC round 5, then issue case 1 -> the aborted block is never
//    output; case 1 is correct with full latency.
//  5 With AES_DEC_KEY_CACHE_EN: case 1 twice back-to-back -> 2nd at T+11.
//    Then case 2 -> T+21, correct pt.
//  6 in_valid toggled with random data while busy -> ignored; the result
//    equals the accepted block only.

Source files
------------

// File: rtl/aes128_dec_iter_pkg.sv
// Shared definitions for the iterative AES-128 decryptor.
// Contents: block/round constants, the forward and inverse S-box tables,
// the first and last round constants, GF(2^8) helpers (xtime, inverse xtime,
// gmul), S-box lookups, one-round key-schedule steps (forward and backward),
// and the FSM state encoding.
// Byte 0 is always the most significant byte of a 128-bit vector.
package aes128_dec_iter_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_BLK_W = 128;

    localparam logic [7:0] RCON_FIRST = 8'h01;
    localparam logic [7:0] RCON_LAST  = 8'h36;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEXP,
        ST_ARK,
        ST_DEC,
        ST_DONE
    } dec_state_t;

    // Entry x sits in bits [8*(255-x) +: 8] so that row 0 reads left to right.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[8*(255-int'(x)) +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX_TBL[8*(255-int'(x)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // xtime reduced with 0x1B leaves bit 0 set, so bit 0 tells whether the
    // dropped top bit was a one.
    function automatic logic [7:0] inv_xtime(input logic [7:0] a);
        return a[0] ? ({1'b1, 7'h00} | ((a ^ 8'h1b) >> 1)) : (a >> 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
    endfunction

    // rk(n) -> rk(n+1); rc is the round constant of round n+1.
    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = k;
        w0 = w0 ^ sub_rot_word(w3) ^ {rc, 24'h000000};
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // rk(n+1) -> rk(n); rc is the round constant that produced rk(n+1).
    // Words are recovered last-to-first so each uses the newer neighbour.
    function automatic logic [127:0] key_bwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = k;
        w3 = w3 ^ w2;
        w2 = w2 ^ w1;
        w1 = w1 ^ w0;
        w0 = w0 ^ sub_rot_word(w3) ^ {rc, 24'h000000};
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes128_dec_iter_if.sv
// Block stream interface of the AES-128 decryptor.
// Input side: in_valid/in_ready handshake carrying ciphertext (in_data) and
// cipher key (in_key). Output side: out_valid/out_ready handshake carrying
// plaintext (out_data). The slave modport is the decryptor's view; the
// master modport is the producer/consumer view.
interface aes128_dec_iter_if;
    import aes128_dec_iter_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [AES_BLK_W-1:0] in_data;
    logic [AES_BLK_W-1:0] in_key;
    logic                 out_valid;
    logic                 out_ready;
    logic [AES_BLK_W-1:0] out_data;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes128_dec_iter_inv_round_comb.sv
// One combinational inverse AES round.
// Ports: blk  (in, 128)  state entering the round
//        rk   (in, 128)  round key for this round
//        last (in, 1)    final round: skip InvMixColumns
//        res  (out, 128) InvSubBytes(InvShiftRows(blk)) ^ rk, then
//                        InvMixColumns unless last
// State bytes are column-major: byte 4*c + r is row r of column c.
module aes128_dec_iter_inv_round_comb
    import aes128_dec_iter_pkg::*;
(
    input  logic [AES_BLK_W-1:0] blk,
    input  logic [AES_BLK_W-1:0] rk,
    input  logic                 last,
    output logic [AES_BLK_W-1:0] res
);

    logic [7:0] ark_b [16];
    logic [7:0] mix_b [16];

    genvar gi;

    // Row r rotates right by r: output column c takes input column c - r.
    for (gi = 0; gi < 16; gi++) begin : g_byte
        localparam int SRC = 4 * (((gi / 4) - (gi % 4) + 4) % 4) + (gi % 4);
        assign ark_b[gi] = inv_sbox(blk[127-8*SRC -: 8]) ^ rk[127-8*gi -: 8];
    end

    for (gi = 0; gi < 4; gi++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = ark_b[4*gi];
        assign a1 = ark_b[4*gi+1];
        assign a2 = ark_b[4*gi+2];
        assign a3 = ark_b[4*gi+3];
        assign mix_b[4*gi]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        assign mix_b[4*gi+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        assign mix_b[4*gi+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        assign mix_b[4*gi+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end

    for (gi = 0; gi < 16; gi++) begin : g_out
        assign res[127-8*gi -: 8] = last ? ark_b[gi] : mix_b[gi];
    end

endmodule

// File: rtl/aes128_dec_iter.sv
// Iterative AES-128 decryptor, one round per clock.
// Ports: clk   (in)  single clock, rising edge
//        reset (in)  synchronous active-high reset; aborts any block in flight
//        bus   (aes128_dec_iter_if.slave) ciphertext/key in, plaintext out
// Flow: IDLE -> KEXP (10 cycles, walk key forward to rk10) -> ARK (1 cycle)
//       -> DEC (10 cycles, key walks back one round per cycle) -> DONE.
// Latency from accept edge to out_valid is 21 cycles.
// Optional macro AES_DEC_KEY_CACHE_EN: remembers the last expanded key and
// its rk10; an accept with the same key skips KEXP (latency 11).
module aes128_dec_iter
    import aes128_dec_iter_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic               clk,
    input  logic               reset,
    aes128_dec_iter_if.slave   bus
);

    localparam logic [3:0] RND_LAST = 4'(NR - 1);

    dec_state_t           fsm_reg, fsm_next;
    logic [3:0]           round_reg, round_next;
    logic [7:0]           rcon_reg, rcon_next;
    logic [AES_BLK_W-1:0] blk_reg, blk_next;
    logic [AES_BLK_W-1:0] key_reg, key_next;
    logic [AES_BLK_W-1:0] round_out;
    logic                 cache_hit;
    logic [AES_BLK_W-1:0] cache_rk10;

    aes128_dec_iter_inv_round_comb u_round (
        .blk  (blk_reg),
        .rk   (key_reg),
        .last (round_reg == 4'd0),
        .res  (round_out)
    );

`ifdef AES_DEC_KEY_CACHE_EN
    logic [AES_BLK_W-1:0] cache_key_reg;
    logic [AES_BLK_W-1:0] cache_rk10_reg;
    logic                 cache_valid_reg;

    assign cache_hit  = cache_valid_reg && (bus.in_key == cache_key_reg);
    assign cache_rk10 = cache_rk10_reg;

    // The source key is captured at accept; the entry only becomes valid once
    // its rk10 has actually been produced, so an aborted KEXP never hits.
    always_ff @(posedge clk) begin
        if (reset) begin
            cache_valid_reg <= 1'b0;
        end else begin
            if (fsm_reg == ST_IDLE && bus.in_valid && !cache_hit) begin
                cache_key_reg   <= bus.in_key;
                cache_valid_reg <= 1'b0;
            end
            if (fsm_reg == ST_KEXP && round_reg == RND_LAST) begin
                cache_rk10_reg  <= key_next;
                cache_valid_reg <= 1'b1;
            end
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_rk10 = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_reg   <= ST_IDLE;
            round_reg <= 4'd0;
            rcon_reg  <= 8'h00;
            blk_reg   <= '0;
            key_reg   <= '0;
        end else begin
            fsm_reg   <= fsm_next;
            round_reg <= round_next;
            rcon_reg  <= rcon_next;
            blk_reg   <= blk_next;
            key_reg   <= key_next;
        end
    end

    always_comb begin
        fsm_next   = fsm_reg;
        round_next = round_reg;
        rcon_next  = rcon_reg;
        blk_next   = blk_reg;
        key_next   = key_reg;
        case (fsm_reg)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    blk_next   = bus.in_data;
                    round_next = 4'd0;
                    if (cache_hit) begin
                        key_next  = cache_rk10;
                        rcon_next = RCON_LAST;
                        fsm_next  = ST_ARK;
                    end else begin
                        key_next  = bus.in_key;
                        rcon_next = RCON_FIRST;
                        fsm_next  = ST_KEXP;
                    end
                end
            end
            ST_KEXP: begin
                key_next = key_fwd(key_reg, rcon_reg);
                // rcon is left at 0x36 after the last step so the walk back
                // starts with the constant that produced rk10.
                if (round_reg == RND_LAST) begin
                    fsm_next = ST_ARK;
                end else begin
                    round_next = round_reg + 4'd1;
                    rcon_next  = xtime(rcon_reg);
                end
            end
            ST_ARK: begin
                blk_next   = blk_reg ^ key_reg;
                key_next   = key_bwd(key_reg, rcon_reg);
                rcon_next  = inv_xtime(rcon_reg);
                round_next = RND_LAST;
                fsm_next   = ST_DEC;
            end
            ST_DEC: begin
                blk_next = round_out;
                if (round_reg == 4'd0) begin
                    fsm_next = ST_DONE;
                end else begin
                    round_next = round_reg - 4'd1;
                    key_next   = key_bwd(key_reg, rcon_reg);
                    if (round_reg != 4'd1) rcon_next = inv_xtime(rcon_reg);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) fsm_next = ST_IDLE;
            end
            default: fsm_next = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = (fsm_reg == ST_IDLE);
    assign bus.out_valid = (fsm_reg == ST_DONE);
    assign bus.out_data  = (fsm_reg == ST_DONE) ? blk_reg : '0;

endmodule
